// File: rtl/forward_source_pkg.sv
// Shared types and constants for the operand-forwarding producer side:
// RV32I major opcodes and the in-flight writer slot record.
package forward_source_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] RTYPE      = 7'b0110011;
  localparam logic [6:0] IMMTYPE    = 7'b0010011;
  localparam logic [6:0] LOAD_ITYPE = 7'b0000011;
  localparam logic [6:0] STYPE      = 7'b0100011;
  localparam logic [6:0] SBTYPE     = 7'b1100011;
  localparam logic [6:0] LUI        = 7'b0110111;
  localparam logic [6:0] AUIPC      = 7'b0010111;
  localparam logic [6:0] JAL        = 7'b1101111;
  localparam logic [6:0] JALR       = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            writes;
    logic            is_load;
    logic [XLEN-1:0] data;
  } slot_t;

  // Stores and branches carry an rd-shaped field that is not a destination.
  function automatic logic opcode_has_rd(input logic [6:0] op);
    return (op != STYPE) && (op != SBTYPE);
  endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Match-and-priority for one EX operand against the MEM (s1) and WB (s2) slots.
module fwd_lookup
  import forward_source_pkg::*;
(
  input  logic [4:0]      rs,
  input  logic            use_rs,
  input  slot_t           s1,
  input  slot_t           s2,
  output logic            hit,
  output logic [XLEN-1:0] data,
  output logic            stall_req
);

  logic s1_match;
  logic s2_match;

  assign s1_match = s1.valid && s1.writes && (s1.rd == rs);
  assign s2_match = s2.valid && s2.writes && (s2.rd == rs);

  always_comb begin
    hit       = 1'b0;
    data      = '0;
    stall_req = 1'b0;
    if (use_rs && (rs != 5'd0)) begin
      // s1 is the younger writer, so it shadows s2 even when its value is not ready yet.
      if (s1_match) begin
        if (s1.is_load) begin
          stall_req = 1'b1;
        end else begin
          hit  = 1'b1;
          data = s1.data;
        end
      end else if (s2_match) begin
        hit  = 1'b1;
        data = s2.data;
      end
    end
  end

endmodule

// File: rtl/forward_source.sv
// Tracks the MEM/WB in-flight writers, forwards their results to EX operands,
// raises the load-use interlock and drives the register-file write port.
module forward_source
  import forward_source_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_result,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic            q_use_rs1,
  input  logic            q_use_rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic            load_use_stall,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  slot_t      ex_slot_p0;
  slot_t      s1_p1;
  slot_t      s2_p2;
  logic [6:0] ex_opcode;
  logic       stall_req1;
  logic       stall_req2;
  logic       unused_inst_bits;

  assign ex_opcode        = ex_inst[6:0];
  assign unused_inst_bits = ^ex_inst[31:12];

  // EX stage: decode the candidate slot contents
  always_comb begin
    ex_slot_p0         = '0;
    ex_slot_p0.valid   = ex_valid;
    ex_slot_p0.rd      = ex_inst[11:7];
    ex_slot_p0.is_load = (ex_opcode == LOAD_ITYPE);
    ex_slot_p0.writes  = ex_valid && opcode_has_rd(ex_opcode) && (ex_inst[11:7] != 5'd0);
    ex_slot_p0.data    = ex_result;
  end

  // EX -> MEM -> WB slot advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p1 <= '0;
      s2_p2 <= '0;
    end else if (!stall) begin
      s2_p2      <= s1_p1;
      s2_p2.data <= s1_p1.is_load ? mem_load_data : s1_p1.data;
      s1_p1      <= (flush || load_use_stall) ? '0 : ex_slot_p0;
    end
  end

  fwd_lookup u_lookup_rs1 (
    .rs        (q_rs1),
    .use_rs    (q_use_rs1),
    .s1        (s1_p1),
    .s2        (s2_p2),
    .hit       (fwd1_hit),
    .data      (fwd1_data),
    .stall_req (stall_req1)
  );

  fwd_lookup u_lookup_rs2 (
    .rs        (q_rs2),
    .use_rs    (q_use_rs2),
    .s1        (s1_p1),
    .s2        (s2_p2),
    .hit       (fwd2_hit),
    .data      (fwd2_data),
    .stall_req (stall_req2)
  );

  assign load_use_stall = stall_req1 | stall_req2;

  // WB stage: register-file write port
  assign wb_we   = s2_p2.valid & s2_p2.writes;
  assign wb_rd   = s2_p2.rd;
  assign wb_data = s2_p2.data;

endmodule

// File: tb/tb_forward_source.sv
// Directed scenarios plus a randomized run against a record-list model of the
// two in-flight writers for forward_source.
module tb_forward_source;
  import forward_source_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_result;
  logic        stall;
  logic        flush;
  logic [31:0] mem_load_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_use_rs1, q_use_rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        load_use_stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit        w;
    bit [4:0]  rd;
    bit        ld;
    bit [31:0] d;
  } rec_t;

  // pipe[0] is the youngest in-flight instruction, pipe[1] the oldest.
  rec_t pipe[2];

  always #5 clk = ~clk;

  forward_source dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_result(ex_result),
    .stall(stall), .flush(flush), .mem_load_data(mem_load_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_use_rs1(q_use_rs1), .q_use_rs2(q_use_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .load_use_stall(load_use_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  function automatic logic [31:0] make_inst(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [19:0] hi);
    return {hi, rd, op};
  endfunction

  function automatic logic [104:0] all_outs();
    return {fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, load_use_stall, wb_we, wb_rd, wb_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_inst = '0; ex_result = '0; stall = 1'b0; flush = 1'b0;
    mem_load_data = '0; q_rs1 = '0; q_rs2 = '0; q_use_rs1 = 1'b0; q_use_rs2 = 1'b0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val);
    ex_valid = 1'b1; ex_inst = make_inst(op, rd, 20'h0); ex_result = val;
    tick();
    ex_valid = 1'b0; ex_inst = '0; ex_result = '0;
  endtask

  function automatic void ref_lookup(input logic [4:0] rs, input logic use_it,
                                     output logic hit, output logic [31:0] d, output logic st);
    bit found;
    hit = 1'b0; d = '0; st = 1'b0; found = 1'b0;
    if (use_it && rs != 5'd0) begin
      for (int i = 0; i < 2; i++) begin
        if (!found && pipe[i].w && pipe[i].rd == rs) begin
          found = 1'b1;
          if (i == 0 && pipe[i].ld) st = 1'b1;
          else begin hit = 1'b1; d = pipe[i].d; end
        end
      end
    end
  endfunction

  task automatic test_reset();
    idle_inputs();
    q_rs1 = 5'd3; q_use_rs1 = 1'b1;
    #2;
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_during got=%h exp=0", all_outs());
    end
    @(negedge clk); rst = 1'b0;
    tick();
    @(negedge clk);
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_after got=%h exp=0", all_outs());
    end
  endtask

  task automatic test_alu_chain();
    idle_inputs();
    issue(RTYPE, 5'd5, 32'd7);
    q_rs1 = 5'd5; q_use_rs1 = 1'b1;
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd1_data, wb_we} !== {1'b1, 32'd7, 1'b0}) begin
      fails++; $display("FAIL alu_s1 got=%h exp=%h", {fwd1_hit, fwd1_data, wb_we}, {1'b1, 32'd7, 1'b0});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd1_data} !== {1'b1, 32'd7}) begin
      fails++; $display("FAIL alu_s2_fwd got=%h exp=%h", {fwd1_hit, fwd1_data}, {1'b1, 32'd7});
    end
    tests++;
    if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd5, 32'd7}) begin
      fails++; $display("FAIL alu_wb got=%h exp=%h", {wb_we, wb_rd, wb_data}, {1'b1, 5'd5, 32'd7});
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    issue(IMMTYPE, 5'd5, 32'd1);
    issue(RTYPE, 5'd5, 32'd2);
    q_rs2 = 5'd5; q_use_rs2 = 1'b1;
    @(negedge clk);
    tests++;
    if ({fwd2_hit, fwd2_data} !== {1'b1, 32'd2}) begin
      fails++; $display("FAIL priority_fwd2 got=%h exp=%h", {fwd2_hit, fwd2_data}, {1'b1, 32'd2});
    end
    tests++;
    if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd5, 32'd1}) begin
      fails++; $display("FAIL priority_wb got=%h exp=%h", {wb_we, wb_rd, wb_data}, {1'b1, 5'd5, 32'd1});
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    issue(LOAD_ITYPE, 5'd6, 32'h100);
    ex_valid = 1'b1; ex_inst = make_inst(RTYPE, 5'd7, 20'h00030); ex_result = 32'h77;
    q_rs1 = 5'd6; q_use_rs1 = 1'b1; mem_load_data = 32'hDEADBEEF;
    @(negedge clk);
    tests++;
    if ({load_use_stall, fwd1_hit, fwd1_data} !== {1'b1, 1'b0, 32'd0}) begin
      fails++; $display("FAIL loaduse_stall got=%h exp=%h", {load_use_stall, fwd1_hit, fwd1_data}, {1'b1, 1'b0, 32'd0});
    end
    tick();
    mem_load_data = 32'h0;
    @(negedge clk);
    tests++;
    if ({load_use_stall, fwd1_hit, fwd1_data} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      fails++; $display("FAIL loaduse_fwd got=%h exp=%h", {load_use_stall, fwd1_hit, fwd1_data}, {1'b0, 1'b1, 32'hDEADBEEF});
    end
    tests++;
    if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd6, 32'hDEADBEEF}) begin
      fails++; $display("FAIL loaduse_wb got=%h exp=%h", {wb_we, wb_rd, wb_data}, {1'b1, 5'd6, 32'hDEADBEEF});
    end
    tick();
    ex_valid = 1'b0; ex_inst = '0; q_rs1 = 5'd7;
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd1_data} !== {1'b1, 32'h77}) begin
      fails++; $display("FAIL loaduse_held_ex got=%h exp=%h", {fwd1_hit, fwd1_data}, {1'b1, 32'h77});
    end
  endtask

  task automatic test_nonwriters();
    idle_inputs();
    issue(STYPE, 5'd5, 32'h55);
    issue(SBTYPE, 5'd5, 32'h56);
    q_rs1 = 5'd5; q_use_rs1 = 1'b1; q_rs2 = 5'd0; q_use_rs2 = 1'b1;
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd2_hit, load_use_stall, wb_we} !== 4'b0000) begin
      fails++; $display("FAIL nonwriter_s1s2 got=%b exp=0000", {fwd1_hit, fwd2_hit, load_use_stall, wb_we});
    end
    issue(IMMTYPE, 5'd0, 32'h57);
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd2_hit, wb_we} !== 3'b000) begin
      fails++; $display("FAIL x0_in_s1 got=%b exp=000", {fwd1_hit, fwd2_hit, wb_we});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({fwd2_hit, fwd2_data, wb_we} !== {1'b0, 32'd0, 1'b0}) begin
      fails++; $display("FAIL x0_in_s2 got=%h exp=0", {fwd2_hit, fwd2_data, wb_we});
    end
  endtask

  task automatic test_stall_flush();
    logic [104:0] exp;
    idle_inputs();
    issue(RTYPE, 5'd3, 32'h33);
    issue(RTYPE, 5'd4, 32'h44);
    stall = 1'b1; flush = 1'b1; ex_valid = 1'b1;
    ex_inst = make_inst(LOAD_ITYPE, 5'd4, 20'h1); ex_result = 32'hAAAA;
    mem_load_data = 32'hBBBB;
    q_rs1 = 5'd4; q_use_rs1 = 1'b1; q_rs2 = 5'd3; q_use_rs2 = 1'b1;
    exp = {1'b1, 32'h44, 1'b1, 32'h33, 1'b0, 1'b1, 5'd3, 32'h33};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (all_outs() !== exp) begin
        fails++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, all_outs(), exp);
      end
      tick();
    end
    stall = 1'b0;
    ex_inst = make_inst(RTYPE, 5'd9, 20'h2); ex_result = 32'h99;
    @(negedge clk);
    tests++;
    if (all_outs() !== exp) begin
      fails++; $display("FAIL stall_release got=%h exp=%h", all_outs(), exp);
    end
    tick();
    flush = 1'b0; ex_valid = 1'b0; ex_inst = '0; q_rs1 = 5'd9; q_rs2 = 5'd4;
    @(negedge clk);
    tests++;
    if ({fwd1_hit, fwd2_hit, fwd2_data} !== {1'b0, 1'b1, 32'h44}) begin
      fails++; $display("FAIL flush_fwd got=%h exp=%h", {fwd1_hit, fwd2_hit, fwd2_data}, {1'b0, 1'b1, 32'h44});
    end
    tests++;
    if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h44}) begin
      fails++; $display("FAIL flush_wb got=%h exp=%h", {wb_we, wb_rd, wb_data}, {1'b1, 5'd4, 32'h44});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({wb_we, fwd2_hit} !== 2'b00) begin
      fails++; $display("FAIL flush_bubble_wb got=%b exp=00", {wb_we, fwd2_hit});
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops[9];
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        h1, h2, st1, st2, exp_lus;
    logic [31:0] d1, d2;
    rec_t        older;
    ops = '{RTYPE, IMMTYPE, LOAD_ITYPE, STYPE, SBTYPE, LUI, AUIPC, JAL, JALR};
    idle_inputs();
    tick();
    tick();
    pipe[0] = '{w: 1'b0, rd: 5'd0, ld: 1'b0, d: 32'd0};
    pipe[1] = pipe[0];
    for (int n = 0; n < 400; n++) begin
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ex_valid  = ($urandom_range(0, 4) != 0);
      op        = ops[$urandom_range(0, 8)];
      rd        = 5'($urandom_range(0, 7));
      ex_inst   = make_inst(op, rd, 20'($urandom));
      ex_result = $urandom;
      mem_load_data = $urandom;
      q_rs1 = 5'($urandom_range(0, 7)); q_use_rs1 = ($urandom_range(0, 3) != 0);
      q_rs2 = 5'($urandom_range(0, 7)); q_use_rs2 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ref_lookup(q_rs1, q_use_rs1, h1, d1, st1);
      ref_lookup(q_rs2, q_use_rs2, h2, d2, st2);
      exp_lus = st1 | st2;
      tests++;
      if ({fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, load_use_stall} !== {h1, d1, h2, d2, exp_lus}) begin
        fails++;
        $display("FAIL rand_fwd[%0d] got=%h exp=%h", n,
                 {fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, load_use_stall}, {h1, d1, h2, d2, exp_lus});
      end
      tests++;
      if ({wb_we, wb_rd, wb_data} !== {pipe[1].w, pipe[1].rd, pipe[1].d}) begin
        fails++;
        $display("FAIL rand_wb[%0d] got=%h exp=%h", n, {wb_we, wb_rd, wb_data}, {pipe[1].w, pipe[1].rd, pipe[1].d});
      end
      @(posedge clk);
      if (!stall) begin
        older = pipe[0];
        if (older.ld) older.d = mem_load_data;
        pipe[1] = older;
        if (flush || exp_lus)
          pipe[0] = '{w: 1'b0, rd: 5'd0, ld: 1'b0, d: 32'd0};
        else
          pipe[0] = '{w: ex_valid && op != STYPE && op != SBTYPE && rd != 5'd0,
                      rd: rd, ld: (op == LOAD_ITYPE), d: ex_result};
      end
      #1;
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    issue(RTYPE, 5'd3, 32'h33);
    issue(LOAD_ITYPE, 5'd4, 32'h44);
    q_rs1 = 5'd3; q_use_rs1 = 1'b1; q_rs2 = 5'd4; q_use_rs2 = 1'b1;
    @(negedge clk);
    tests++;
    if ({fwd1_hit, load_use_stall, wb_we} !== 3'b111) begin
      fails++; $display("FAIL reset_mid_pre got=%b exp=111", {fwd1_hit, load_use_stall, wb_we});
    end
    #1;
    stall = 1'b1; rst = 1'b1;
    #1;
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_mid_async got=%h exp=0", all_outs());
    end
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;
    tick();
    @(negedge clk);
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL reset_mid_after got=%h exp=0", all_outs());
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_chain();
    test_priority();
    test_load_use();
    test_nonwriters();
    test_stall_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/forward_source.md
# forward_source

Producer-side companion to the operand-forwarding detector. Tracks the two in-flight older instructions (MEM and WB positions) that may write a destination register, and serves the instruction in EX with forwarded operand values. Requests a one-cycle interlock when an operand depends on a load still in MEM, and drives the register-file write port from the WB position.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX instruction is real (not a bubble)
- ex_inst  in  32  EX instruction word (RV32I encoding)
- ex_result  in  XLEN  EX result (ALU, LUI/AUIPC value, JAL/JALR link address)
- stall  in  1  global freeze; all state holds
- flush  in  1  kill the EX instruction (capture a bubble instead)
- mem_load_data  in  XLEN  load data for the S1 instruction, sampled at the end of its S1 cycle
- q_rs1, q_rs2  in  5  operand register indices of the instruction currently in EX
- q_use_rs1, q_use_rs2  in  1  EX instruction actually reads that operand
- fwd1_hit, fwd2_hit  out  1  forward the corresponding operand
- fwd1_data, fwd2_data  out  XLEN  forwarded value
- load_use_stall  out  1  hold EX and earlier stages this cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- wb_data  out  XLEN  register-file write data

## Operation
- Two slots: S1 (MEM position) and S2 (WB position). Each slot holds valid, rd, writes, is_load, and data.
- Decode on capture, from ex_inst:
  - rd = [11:7]
  - is_load = opcode 0000011
  - writes = ex_valid, opcode not 0100011/1100011, and rd≠0
- Capture priority each clock edge:
  1. rst: clear all.
  2. stall: hold all.
  3. Otherwise, S2 ← S1, with S2.data = S1.is_load ? mem_load_data : S1.data.
  4. S1 ← bubble if flush or load_use_stall; otherwise S1 ← EX fields, with data = ex_result.
- Lookup for each operand n (combinational). rs = q_rsn; a slot matches when valid, writes, and rd==rs.
  - If q_use_rsn=0 or rs==0, there is no hit.
  - Else if S1 matches and S1.is_load, hit=0 and a stall is requested.
  - Else if S1 matches, hit=1 and data=S1.data.
  - Else if S2 matches, hit=1 and data=S2.data.
  - Else hit=0.
- S1 has priority over S2, because S1 is the younger writer.
- load_use_stall = OR of the stall requests from both operands. It is asserted even while stall=1, but has no effect on state then.
- wb_we = S2.valid & S2.writes; wb_rd = S2.rd; wb_data = S2.data.
- fwdN_data is 0 whenever fwdN_hit=0.

## Timing
- Reset: all slots invalid, with rd, data, and flags all 0. Every output is therefore 0 during and after reset, until the first capture.
- Capture-to-visibility: an EX instruction accepted at edge k is visible in S1 (forwardable) during cycle k+1. It is in S2 and drives wb_* during cycle k+2.
- Load-use: if a load is in S1 and EX depends on it, load_use_stall=1 for exactly one cycle. At that edge the load moves to S2 (data = mem_load_data) and a bubble enters S1. In the next cycle the EX instruction, held by the core, hits in S2 and load_use_stall=0.
- Simultaneous flush and load_use_stall: S1 gets a bubble, and S2 still advances.
- Simultaneous stall with anything: stall wins; no state changes.
- Writes to x0 never forward and never assert wb_we.
- Reset asserted mid-stream clears state immediately (asynchronous), regardless of stall.

## Structure
- Shared package holds:
  - opcode constants: RTYPE, IMMTYPE, LOAD_ITYPE, STYPE, SBTYPE, LUI, AUIPC, JAL, JALR
  - slot struct: valid, rd, writes, is_load, data
- One sub-module, `fwd_lookup`: combinational match and priority for a single operand. It is instantiated twice, for rs1 and rs2.
- Slots are plain registers in the top.

## Test plan
- ALU chain:
  - add x5 = 7 captured; next cycle query rs1=5 → fwd1_hit=1, data=7.
  - Cycle after that → data=7 via S2, with wb_we=1, wb_rd=5, wb_data=7.
- Priority: writes to x5 of 1 (older) then 2 (younger) back-to-back; query rs2=5 → fwd2_data=2.
- Load-use:
  - lw x6 in S1; EX queries rs1=6 → load_use_stall=1 for one cycle, fwd1_hit=0.
  - mem_load_data=0xDEAD_BEEF; next cycle → fwd1_hit=1, data=0xDEADBEEF, load_use_stall=0.
- Non-writers and x0: sw with rd-field 5, beq with rd-field 5, and addi x0 → no hit on rs=5 or rs=0; wb_we=0.
- Stall/flush:
  - stall=1 for 3 cycles → outputs are constant.
  - flush at capture → S1 is invalid next cycle, and the older S2 contents still write back.
- Reset mid-operation: assert rst asynchronously with both slots valid → all outputs are 0 before the next clock edge.
